vga_framebuffer_scanout: RTL and testbench
==========================================

Name: vga_framebuffer_scanout

Overview:
Parametrised scan-out engine: generates VGA timing, issues framebuffer read addresses and converts packed RGB pixels to 8-bit-per-channel video.
- Generalises the current 256x256 RGB555 top-level path with configurable timing, framebuffer geometry, integer pixel scaling, address ordering, border colour and RAM read latency.
- Sits between the synchronous block-RAM framebuffer and the VGA DAC pins.
- hsync, vsync, blank_n and RGB leave the block cycle-aligned.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT / H_SYNC / H_BACK, 16 / 96 / 48, horizontal porch and sync widths in clocks
V_VISIBLE, 480, visible lines per frame
V_FRONT / V_SYNC / V_BACK, 10 / 2 / 33, vertical porch and sync widths in lines
SYNC_ACTIVE, 0, active level of hsync/vsync
FB_COL_BITS / FB_ROW_BITS, 8 / 8, log2 of framebuffer width/height
SCALE_LOG2, 0, pixel replication factor 2^SCALE_LOG2 (0..3) in both axes
COL_MAJOR, 1, 1: address={col,row}; 0: address={row,col}
CH_W, 5, bits per colour channel in stored pixel (PIX_W=3*CH_W)
RAM_LAT, 1, read latency of framebuffer in clocks (1..3)
BORDER_RGB, 24'h000000, colour for visible area outside framebuffer window

Ports:
clock  in  1  system/pixel clock
reset  in  1  synchronous, active-high
ram_addr  out  FB_COL_BITS+FB_ROW_BITS  framebuffer read address
ram_rd_en  out  1  high when ram_addr targets an in-window pixel
ram_q  in  3*CH_W  pixel data, valid RAM_LAT clocks after address
red / green / blue  out  8 each  output colour
hsync / vsync  out  1  sync pulses, SYNC_ACTIVE polarity
blank_n  out  1  high only during visible pixels
frame_start  out  1  one-clock pulse aligned with output of pixel (0,0)

Behaviour:
- Reset (synchronous, active-high): h=v=0; whole pipeline flushed. Next edge gives red/green/blue=0, hsync=vsync=!SYNC_ACTIVE, blank_n=0, frame_start=0, ram_rd_en=0, ram_addr=0.
- Counters: h counts 0..H_TOTAL-1 with H_TOTAL=sum of the four H_* parameters. On wrap, h goes to 0 and v increments. v wraps at V_TOTAL-1 to 0.
- Raw flags at stage 0:
  - visible = h<H_VISIBLE && v<V_VISIBLE
  - hsync active for H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC
  - vsync active likewise in lines
- Window: fb_col=h>>SCALE_LOG2, fb_row=v>>SCALE_LOG2. in_win = visible && fb_col<2^FB_COL_BITS && fb_row<2^FB_ROW_BITS.
- Address: ram_addr and ram_rd_en are registered from stage 0 (stage 1). ram_addr is driven from the low bits of fb_col/fb_row in the COL_MAJOR order. ram_rd_en=in_win.
- Pipeline: visible, in_win, hsync, vsync and frame flag are delayed PIPE=RAM_LAT+2 clocks. All outputs are registered at the final stage.
- Output latency: counter value at clock t appears on the pins at clock t+PIPE.
- Colour at final stage:
  - in_win: each channel expanded to 8 bits by MSB replication, {c, c[CH_W-1 -: 8-CH_W]}.
  - visible && !in_win: BORDER_RGB.
  - else: 0.
  - Constraint: 8-CH_W <= CH_W; CH_W=8 passes through unchanged.
- blank_n = delayed visible. Sync polarity does not affect blank_n.
- frame_start pulses exactly once per frame.
- Reset mid-frame: counters restart at (0,0) on the next clock. Outputs are blank/inactive until the new frame's first pixel reaches the pins PIPE clocks later. No partial-pixel glitch is emitted.
- ram_q is ignored whenever the delayed in_win is 0.

Decomposition:
- Shared package vga_pkg:
  - H_TOTAL/V_TOTAL derivation and counter width helpers (clog2)
  - default 640x480@60 timing constants
  - channel-expand function
- Sub-module vga_timing_counter: h/v counters plus raw visible/hsync/vsync/frame flags. The scan-out block adds the address stage, delay lines and colour mux.

Test Plan:
- Reset, defaults (RAM_LAT=1, PIPE=3): hold reset 5 clocks → red/green/blue=0, hsync=vsync=1, blank_n=0. Release; frame_start high on the 3rd clock after release and blank_n=1 on the same clock.
- Sync timing, defaults: hsync low for exactly 96 clocks starting 659 clocks after line start (656+PIPE). vsync low for 2 full lines (1600 clocks); line period 800, frame period 420000.
- Addressing, COL_MAJOR=1 vs 0 at h=3, v=5 → ram_addr=16'h0305 vs 16'h0503, with ram_rd_en=1. At h=256, v=0 → ram_rd_en=0 and output=BORDER_RGB (set 24'h123456).
- SCALE_LOG2=1 → fb_col advances every 2 clocks; window ends at h=512; h=512..639 shows border.
- Colour expansion: ram_q=15'h7FFF → FF/FF/FF; ram_q=15'h4210 → 84/84/84; ram_q=0 → 00/00/00. Repeat with RAM_LAT=3 and confirm the pixel stays aligned with blank_n (PIPE=5).
- Reset asserted at h=400, v=200 for 1 clock → counters (0,0) next clock; no non-zero RGB until the new frame_start; frame_start fires PIPE clocks after deassertion.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared timing defaults, width helpers and colour expansion for VGA scan-out
package vga_pkg;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    typedef struct packed {
        logic visible;
        logic in_win;
        logic hsync;
        logic vsync;
        logic frame;
    } vga_flags_t;

    function automatic int total4(input int a, input int b, input int c, input int d);
        return a + b + c + d;
    endfunction

    // Wide enough to hold the total itself, so sync-end compares never overflow.
    function automatic int cnt_w(input int total);
        return $clog2(total + 1);
    endfunction

    // c_left holds the channel MSB-aligned; OR-ing in a shifted copy replicates its MSBs.
    function automatic logic [7:0] expand_ch(input logic [7:0] c_left, input int ch_w);
        return c_left | (c_left >> ch_w);
    endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// rtl/vga_timing_counter.sv - h/v raster counters with raw visible/sync/frame flags
module vga_timing_counter
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    localparam int H_TOTAL  = total4(H_VISIBLE, H_FRONT, H_SYNC, H_BACK),
    localparam int V_TOTAL  = total4(V_VISIBLE, V_FRONT, V_SYNC, V_BACK),
    localparam int HW       = cnt_w(H_TOTAL),
    localparam int VW       = cnt_w(V_TOTAL)
) (
    input  logic          clock,
    input  logic          reset,
    output logic [HW-1:0] h,
    output logic [VW-1:0] v,
    output logic          visible,
    output logic          hsync_act,
    output logic          vsync_act,
    output logic          frame
);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS_C  = HW'(H_VISIBLE);
    localparam logic [VW-1:0] V_VIS_C  = VW'(V_VISIBLE);
    localparam logic [HW-1:0] HS_START = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] HS_END   = HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] VS_START = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] VS_END   = VW'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;

    always_comb begin
        h_d = h_q + 1'b1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    always_comb begin
        h         = h_q;
        v         = v_q;
        visible   = (h_q < H_VIS_C) && (v_q < V_VIS_C);
        hsync_act = (h_q >= HS_START) && (h_q < HS_END);
        vsync_act = (v_q >= VS_START) && (v_q < VS_END);
        frame     = (h_q == '0) && (v_q == '0);
    end

endmodule

// File: rtl/vga_framebuffer_scanout.sv
// rtl/vga_framebuffer_scanout.sv - framebuffer address stage, flag delay line and colour output mux
module vga_framebuffer_scanout
    import vga_pkg::*;
#(
    parameter int          H_VISIBLE   = DEF_H_VISIBLE,
    parameter int          H_FRONT     = DEF_H_FRONT,
    parameter int          H_SYNC      = DEF_H_SYNC,
    parameter int          H_BACK      = DEF_H_BACK,
    parameter int          V_VISIBLE   = DEF_V_VISIBLE,
    parameter int          V_FRONT     = DEF_V_FRONT,
    parameter int          V_SYNC      = DEF_V_SYNC,
    parameter int          V_BACK      = DEF_V_BACK,
    parameter logic        SYNC_ACTIVE = 1'b0,
    parameter int          FB_COL_BITS = 8,
    parameter int          FB_ROW_BITS = 8,
    parameter int          SCALE_LOG2  = 0,
    parameter bit          COL_MAJOR   = 1'b1,
    parameter int          CH_W        = 5,
    parameter int          RAM_LAT     = 1,
    parameter logic [23:0] BORDER_RGB  = 24'h000000
) (
    input  logic                               clock,
    input  logic                               reset,
    output logic [FB_COL_BITS+FB_ROW_BITS-1:0] ram_addr,
    output logic                               ram_rd_en,
    input  logic [3*CH_W-1:0]                  ram_q,
    output logic [7:0]                         red,
    output logic [7:0]                         green,
    output logic [7:0]                         blue,
    output logic                               hsync,
    output logic                               vsync,
    output logic                               blank_n,
    output logic                               frame_start
);

    localparam int HW = cnt_w(total4(H_VISIBLE, H_FRONT, H_SYNC, H_BACK));
    localparam int VW = cnt_w(total4(V_VISIBLE, V_FRONT, V_SYNC, V_BACK));
    localparam int AW = FB_COL_BITS + FB_ROW_BITS;

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          visible, hsync_act, vsync_act, frame;

    vga_timing_counter #(
        .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
        .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
    ) u_timing (
        .clock     (clock),
        .reset     (reset),
        .h         (h),
        .v         (v),
        .visible   (visible),
        .hsync_act (hsync_act),
        .vsync_act (vsync_act),
        .frame     (frame)
    );

    logic [31:0]   fb_col, fb_row;
    logic          in_win;
    logic [AW-1:0] ram_addr_d, ram_addr_q;
    logic          ram_rd_en_d, ram_rd_en_q;
    vga_flags_t    pipe_d [RAM_LAT+1];
    vga_flags_t    pipe_q [RAM_LAT+1];

    // Out-of-window test uses the bits above the framebuffer size, so any counter width works.
    always_comb begin
        fb_col      = 32'(h) >> SCALE_LOG2;
        fb_row      = 32'(v) >> SCALE_LOG2;
        in_win      = visible && ((fb_col >> FB_COL_BITS) == 32'd0)
                              && ((fb_row >> FB_ROW_BITS) == 32'd0);
        ram_addr_d  = COL_MAJOR ? {fb_col[FB_COL_BITS-1:0], fb_row[FB_ROW_BITS-1:0]}
                                : {fb_row[FB_ROW_BITS-1:0], fb_col[FB_COL_BITS-1:0]};
        ram_rd_en_d = in_win;
        pipe_d[0]   = '{visible: visible, in_win: in_win, hsync: hsync_act,
                        vsync: vsync_act, frame: frame};
        for (int i = 1; i <= RAM_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // pipe_q[RAM_LAT] lines up with ram_q; the output registers add the last stage.
    vga_flags_t          fin;
    logic [CH_W+7:0]     r_ext, g_ext, b_ext;
    logic [23:0]         rgb_d, rgb_q;
    logic                hsync_d, hsync_q, vsync_d, vsync_q;
    logic                blank_n_d, blank_n_q, frame_start_d, frame_start_q;

    always_comb begin
        fin           = pipe_q[RAM_LAT];
        r_ext         = {ram_q[3*CH_W-1 -: CH_W], 8'h00};
        g_ext         = {ram_q[2*CH_W-1 -: CH_W], 8'h00};
        b_ext         = {ram_q[CH_W-1:0], 8'h00};
        rgb_d         = 24'h000000;
        if (fin.in_win) begin
            rgb_d = {expand_ch(r_ext[CH_W+7 -: 8], CH_W),
                     expand_ch(g_ext[CH_W+7 -: 8], CH_W),
                     expand_ch(b_ext[CH_W+7 -: 8], CH_W)};
        end else if (fin.visible) begin
            rgb_d = BORDER_RGB;
        end
        hsync_d       = fin.hsync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_d       = fin.vsync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        blank_n_d     = fin.visible;
        frame_start_d = fin.frame;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ram_addr_q    <= '0;
            ram_rd_en_q   <= 1'b0;
            for (int i = 0; i <= RAM_LAT; i++) begin
                pipe_q[i] <= '0;
            end
            rgb_q         <= 24'h000000;
            hsync_q       <= ~SYNC_ACTIVE;
            vsync_q       <= ~SYNC_ACTIVE;
            blank_n_q     <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            ram_addr_q    <= ram_addr_d;
            ram_rd_en_q   <= ram_rd_en_d;
            for (int i = 0; i <= RAM_LAT; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
            rgb_q         <= rgb_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            blank_n_q     <= blank_n_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign ram_addr    = ram_addr_q;
    assign ram_rd_en   = ram_rd_en_q;
    assign red         = rgb_q[23:16];
    assign green       = rgb_q[15:8];
    assign blue        = rgb_q[7:0];
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign blank_n     = blank_n_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_framebuffer_scanout.sv
// tb/tb_vga_framebuffer_scanout.sv - directed self-checking bench for vga_framebuffer_scanout
module tb_vga_framebuffer_scanout;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int ecnt = 0;

    // dut_a: defaults, column-major, latency 1
    logic [15:0] addr_a;
    logic        rd_a, hs_a, vs_a, bl_a, fs_a;
    logic [14:0] q_a;
    logic [7:0]  r_a, g_a, b_a;
    // dut_b: row-major, 2x scaling, latency 3
    logic [15:0] addr_b;
    logic        rd_b, hs_b, vs_b, bl_b, fs_b;
    logic [14:0] q_b, qb1, qb2;
    logic [7:0]  r_b, g_b, b_b;
    // dut_c: tiny raster, active-high sync, 4x4 framebuffer
    logic [3:0]  addr_c;
    logic        rd_c, hs_c, vs_c, bl_c, fs_c;
    logic [14:0] q_c;
    logic [7:0]  r_c, g_c, b_c;

    vga_framebuffer_scanout #(.BORDER_RGB(24'h123456)) dut_a (
        .clock(clk), .reset(reset), .ram_addr(addr_a), .ram_rd_en(rd_a), .ram_q(q_a),
        .red(r_a), .green(g_a), .blue(b_a), .hsync(hs_a), .vsync(vs_a),
        .blank_n(bl_a), .frame_start(fs_a));

    vga_framebuffer_scanout #(.COL_MAJOR(1'b0), .SCALE_LOG2(1), .RAM_LAT(3),
                              .BORDER_RGB(24'h123456)) dut_b (
        .clock(clk), .reset(reset), .ram_addr(addr_b), .ram_rd_en(rd_b), .ram_q(q_b),
        .red(r_b), .green(g_b), .blue(b_b), .hsync(hs_b), .vsync(vs_b),
        .blank_n(bl_b), .frame_start(fs_b));

    vga_framebuffer_scanout #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
                              .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
                              .SYNC_ACTIVE(1'b1), .FB_COL_BITS(2), .FB_ROW_BITS(2),
                              .BORDER_RGB(24'hABCDEF)) dut_c (
        .clock(clk), .reset(reset), .ram_addr(addr_c), .ram_rd_en(rd_c), .ram_q(q_c),
        .red(r_c), .green(g_c), .blue(b_c), .hsync(hs_c), .vsync(vs_c),
        .blank_n(bl_c), .frame_start(fs_c));

    function automatic logic [14:0] ram_fn(input logic [15:0] a);
        case (a)
            16'h0000:           return 15'h7FFF;
            16'h0100, 16'h0001: return 15'h4210;
            16'h0200, 16'h0002: return 15'h0000;
            default:            return a[14:0] ^ 15'h2AAA;
        endcase
    endfunction

    always @(posedge clk) begin
        q_a <= ram_fn(addr_a);
        qb1 <= ram_fn(addr_b);
        qb2 <= qb1;
        q_b <= qb2;
        q_c <= ram_fn({12'h000, addr_c});
        ecnt <= reset ? 0 : ecnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_k(input int k);
        int guard = 0;
        while (ecnt < k && guard < 20000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (ecnt != k) begin
            total++;
            bad++;
            $error("FAIL wait_k observed=%0d expected=%0d", ecnt, k);
        end
    endtask

    initial begin
        repeat (5) @(posedge clk);
        #1;
        chk("rst_rgb_a", {r_a, g_a, b_a}, 24'h000000);
        chk("rst_hs_a", hs_a, 1);
        chk("rst_vs_a", vs_a, 1);
        chk("rst_blank_a", bl_a, 0);
        chk("rst_fs_a", fs_a, 0);
        chk("rst_rd_a", rd_a, 0);
        chk("rst_addr_a", addr_a, 0);
        chk("rst_hs_c", hs_c, 0);
        reset = 1'b0;

        wait_k(2);
        chk("k2_fs_a", fs_a, 0);
        chk("k2_blank_a", bl_a, 0);
        wait_k(3);
        chk("k3_fs_a", fs_a, 1);
        chk("k3_blank_a", bl_a, 1);
        chk("k3_rgb_a_7fff", {r_a, g_a, b_a}, 24'hFFFFFF);
        chk("k3_fs_c", fs_c, 1);
        chk("k3_rgb_c", {r_c, g_c, b_c}, 24'hFFFFFF);
        wait_k(4);
        chk("k4_fs_a", fs_a, 0);
        chk("k4_rgb_a_4210", {r_a, g_a, b_a}, 24'h848484);
        chk("k4_blank_b", bl_b, 0);
        chk("k4_fs_b", fs_b, 0);
        wait_k(5);
        chk("k5_rgb_a_0", {r_a, g_a, b_a}, 24'h000000);
        chk("k5_blank_a", bl_a, 1);
        chk("k5_fs_b", fs_b, 1);
        chk("k5_blank_b", bl_b, 1);
        chk("k5_rgb_b", {r_b, g_b, b_b}, 24'hFFFFFF);
        wait_k(6);
        chk("k6_rgb_b_rep", {r_b, g_b, b_b}, 24'hFFFFFF);
        wait_k(7);
        chk("k7_rgb_b_4210", {r_b, g_b, b_b}, 24'h848484);
        chk("k7_border_c", {r_c, g_c, b_c}, 24'hABCDEF);
        chk("k7_blank_c", bl_c, 1);
        wait_k(9);
        chk("k9_rgb_b_0", {r_b, g_b, b_b}, 24'h000000);
        wait_k(12);
        chk("c_hs_before", hs_c, 0);
        wait_k(13);
        chk("c_hs_first", hs_c, 1);
        wait_k(15);
        chk("c_hs_last", hs_c, 1);
        wait_k(16);
        chk("c_hs_after", hs_c, 0);
        wait_k(82);
        chk("c_vs_before", vs_c, 0);
        wait_k(83);
        chk("c_vs_first", vs_c, 1);
        wait_k(114);
        chk("c_vs_last", vs_c, 1);
        wait_k(115);
        chk("c_vs_after", vs_c, 0);
        wait_k(130);
        chk("c_fs_before", fs_c, 0);
        wait_k(131);
        chk("c_fs_frame2", fs_c, 1);
        wait_k(256);
        chk("a_rd_col255", rd_a, 1);
        wait_k(257);
        chk("a_rd_col256", rd_a, 0);
        wait_k(259);
        chk("a_border", {r_a, g_a, b_a}, 24'h123456);
        wait_k(512);
        chk("b_rd_h511", rd_b, 1);
        wait_k(513);
        chk("b_rd_h512", rd_b, 0);
        wait_k(516);
        chk("b_rgb_h511", {r_b, g_b, b_b}, 24'h5294AD);
        wait_k(517);
        chk("b_border_h512", {r_b, g_b, b_b}, 24'h123456);
        wait_k(643);
        chk("a_porch_blank", bl_a, 0);
        chk("a_porch_rgb", {r_a, g_a, b_a}, 24'h000000);
        wait_k(658);
        chk("a_hs_before", hs_a, 1);
        wait_k(659);
        chk("a_hs_first", hs_a, 0);
        wait_k(754);
        chk("a_hs_last", hs_a, 0);
        wait_k(755);
        chk("a_hs_after", hs_a, 1);
        wait_k(802);
        chk("a_line_end_blank", bl_a, 0);
        wait_k(803);
        chk("a_line1_blank", bl_a, 1);
        chk("a_line1_rgb", {r_a, g_a, b_a}, 24'h848484);
        chk("a_line1_fs", fs_a, 0);
        wait_k(4004);
        chk("a_addr_h3v5", addr_a, 16'h0305);
        chk("a_rd_h3v5", rd_a, 1);
        wait_k(8007);
        chk("b_addr_h6v10", addr_b, 16'h0503);
        chk("b_rd_h6v10", rd_b, 1);

        wait_k(8400);
        chk("pre_rst_rgb_a", {r_a, g_a, b_a}, 24'h123456);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("mid_rst_rgb_a", {r_a, g_a, b_a}, 24'h000000);
        chk("mid_rst_blank_a", bl_a, 0);
        chk("mid_rst_hs_a", hs_a, 1);
        chk("mid_rst_rd_a", rd_a, 0);
        chk("mid_rst_rgb_b", {r_b, g_b, b_b}, 24'h000000);
        wait_k(1);
        chk("mr1_addr_a", addr_a, 16'h0000);
        chk("mr1_rd_a", rd_a, 1);
        chk("mr1_rgb_a", {r_a, g_a, b_a}, 24'h000000);
        wait_k(2);
        chk("mr2_rgb_a", {r_a, g_a, b_a}, 24'h000000);
        chk("mr2_fs_a", fs_a, 0);
        wait_k(3);
        chk("mr3_fs_a", fs_a, 1);
        chk("mr3_rgb_a", {r_a, g_a, b_a}, 24'hFFFFFF);
        wait_k(4);
        chk("mr4_rgb_b", {r_b, g_b, b_b}, 24'h000000);
        chk("mr4_blank_b", bl_b, 0);
        wait_k(5);
        chk("mr5_fs_b", fs_b, 1);
        chk("mr5_rgb_b", {r_b, g_b, b_b}, 24'hFFFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
